// File: rtl/pwm_decoder_pkg.sv
// Shared types and constants for the PWM decoder.
//   PWM_N           : default width of the duty/period results
//   pwm_dec_state_t : decoder state machine encoding (SYNC, HIGH, LOW)
//   maj3            : 2-of-3 majority vote used by the optional glitch filter
package pwm_pkg;

  localparam int PWM_N = 8;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_dec_state_t;

  function automatic logic maj3(input logic [2:0] v);
    maj3 = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// Signal bundle between the PWM decoder and its environment.
//   ena, step, pwm_in                  : enable, sample strobe, raw PWM line
//   duty, period, valid, static_line   : measurement results
//   master : decoder side (consumes controls, drives results)
//   slave  : environment side (drives controls, consumes results)
interface pwm_decoder_if import pwm_pkg::*; #(
  parameter int N = PWM_N
);
  logic         ena;
  logic         step;
  logic         pwm_in;
  logic [N-1:0] duty;
  logic [N-1:0] period;
  logic         valid;
  logic         static_line;

  modport master (
    input  ena, step, pwm_in,
    output duty, period, valid, static_line
  );

  modport slave (
    output ena, step, pwm_in,
    input  duty, period, valid, static_line
  );
endinterface

// File: rtl/pwm_decoder_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk, rst : clock, asynchronous active-high reset (flops clear to 0)
//   d        : asynchronous input, W bits
//   q        : synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= {W{1'b0}};
      sync_q <= {W{1'b0}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time (duty) and period of pwm_in in step ticks.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pwm_decoder_if.master (ena, step, pwm_in in; duty, period,
//              valid, static_line out; all results registered)
// A result is published on every rising edge seen in LOW; a line without
// edges for 2^N steps publishes a timeout result with static_line set.
// Optional build macro PWM_DECODER_GLITCH_FILTER_EN: edge detection uses the
// 2-of-3 majority of the last three step samples instead of the raw sample.
module pwm_decoder import pwm_pkg::*; #(
  parameter int N = PWM_N
) (
  input  logic          clk,
  input  logic          rst,
  pwm_decoder_if.master bus
);
  localparam logic [N:0] CNT_ZERO = {(N + 1){1'b0}};
  localparam logic [N:0] CNT_ONE  = {{N{1'b0}}, 1'b1};
  localparam logic [N:0] CNT_TOP  = {1'b1, {N{1'b0}}};

  pwm_dec_state_t state_q, state_d;
  logic [N:0]     high_cnt_q, high_cnt_d;
  logic [N:0]     period_cnt_q, period_cnt_d;
  logic           prev_q, prev_d;
  logic [N-1:0]   duty_q, duty_d;
  logic [N-1:0]   period_q, period_d;
  logic           valid_q, valid_d;
  logic           static_q, static_d;

  logic           s;
  logic           samp;
  logic           rise;
  logic           tmo;
  logic [N:0]     period_inc;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pwm_in),
    .q   (s)
  );

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  // hist_q[0] is the previous step sample, hist_q[1] the one before it.
  logic [1:0] hist_q, hist_d;

  // Shift the filter history on every strobe.
  always_comb begin
    if (bus.step) begin
      hist_d = {hist_q[0], s};
    end else begin
      hist_d = hist_q;
    end
  end

  // Filter history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign samp = maj3({hist_q, s});
`else
  assign samp = s;
`endif

  // HIGH is only ever entered with prev=1, so a rise can occur only in SYNC
  // or LOW; a rise there takes priority over the timeout.
  assign rise       = samp & ~prev_q;
  assign period_inc = period_cnt_q + CNT_ONE;
  assign tmo        = (period_inc == CNT_TOP) && !rise;

  // Previous step sample for edge detection.
  always_comb begin
    if (bus.step) begin
      prev_d = samp;
    end else begin
      prev_d = prev_q;
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d      = state_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    duty_d       = duty_q;
    period_d     = period_q;
    static_d     = static_q;
    valid_d      = 1'b0;
    if (!bus.ena) begin
      state_d      = SYNC;
      high_cnt_d   = CNT_ZERO;
      period_cnt_d = CNT_ZERO;
    end else if (!bus.step) begin
      state_d = state_q;
    end else if (tmo) begin
      duty_d       = {N{samp}};
      period_d     = {N{1'b1}};
      static_d     = 1'b1;
      valid_d      = 1'b1;
      state_d      = SYNC;
      high_cnt_d   = CNT_ZERO;
      period_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        SYNC: begin
          // The period counter runs here only to time out a static line.
          if (rise) begin
            high_cnt_d   = CNT_ONE;
            period_cnt_d = CNT_ONE;
            state_d      = HIGH;
          end else begin
            period_cnt_d = period_inc;
          end
        end
        HIGH: begin
          if (samp) begin
            high_cnt_d   = high_cnt_q + CNT_ONE;
            period_cnt_d = period_inc;
          end else begin
            period_cnt_d = period_inc;
            state_d      = LOW;
          end
        end
        LOW: begin
          if (rise) begin
            duty_d       = high_cnt_q[N-1:0];
            period_d     = period_cnt_q[N-1:0];
            static_d     = 1'b0;
            valid_d      = 1'b1;
            high_cnt_d   = CNT_ONE;
            period_cnt_d = CNT_ONE;
            state_d      = HIGH;
          end else begin
            period_cnt_d = period_inc;
          end
        end
        default: begin
          state_d      = SYNC;
          high_cnt_d   = CNT_ZERO;
          period_cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      high_cnt_q   <= CNT_ZERO;
      period_cnt_q <= CNT_ZERO;
      prev_q       <= 1'b0;
      duty_q       <= {N{1'b0}};
      period_q     <= {N{1'b0}};
      valid_q      <= 1'b0;
      static_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      prev_q       <= prev_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      static_q     <= static_d;
    end
  end

  assign bus.duty        = duty_q;
  assign bus.period      = period_q;
  assign bus.valid       = valid_q;
  assign bus.static_line = static_q;
endmodule
